intpol2_d4_ctrl: RTL and testbench

//  Sequencing FSM for the quadratic-interpolator datapath (intpol2_D4_Datapath).

---
 rtl/intpol2_d4_pkg.sv | 26 ++
 rtl/intpol2_d4_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_intpol2_d4_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/intpol2_d4_pkg.sv
// Shared definitions for the quadratic-interpolator controller: state
// encoding and xi^2 update-mode codes driven on sel_xi2.
package intpol2_d4_pkg;

   localparam int unsigned SEL_XI2_W = 2;

   // xi^2 accumulator update modes
   localparam logic [SEL_XI2_W-1:0] SEL_XI2_HOLD  = 2'd0;
   localparam logic [SEL_XI2_W-1:0] SEL_XI2_FIRST = 2'd1;
   localparam logic [SEL_XI2_W-1:0] SEL_XI2_STEP  = 2'd2;

   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 4'd0,
      LOAD0 = 4'd1,
      LOAD1 = 4'd2,
      LOAD2 = 4'd3,
      COEF  = 4'd4,
      MUL1  = 4'd5,
      MUL2  = 4'd6,
      OUT   = 4'd7,
      SHIFT = 4'd8
   } state_t;

endpackage

// File: rtl/intpol2_d4_ctrl.sv
// Sequencing controller for the quadratic-interpolator datapath.
// Loads a three-sample window, registers the p1/p2 coefficients, steps the
// shared multiplier N_POINTS times per window and hands each result out over
// valid/ready, then slides the window by one sample.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   start, stop                    run control (stop only honoured in SHIFT)
//   busy                           high outside IDLE
//   in_valid / in_ready            sample handshake
//   out_valid / out_ready          result handshake
//   clear                          zero xi / xi^2 accumulators
//   Ld_M0, Ld_M1, Ld_M2            initial window loads
//   en_stream                      slide window by one sample
//   op_1                           register p1 / p2
//   sel_mult                       0: p1*xi, 1: p2*xi^2
//   Ld_p1_xi, Ld_data              capture product / result
//   en_sum, sel_xi2                advance xi and select xi^2 update mode
//   out_cnt (16 bit)               result counter, only when
//                                  INTPOL2_D4_CTRL_CNT_EN is defined
module intpol2_d4_ctrl
   import intpol2_d4_pkg::*;
#(
   parameter int unsigned N_POINTS = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 stop,
   output logic                 busy,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 clear,
   output logic                 Ld_M0,
   output logic                 Ld_M1,
   output logic                 Ld_M2,
   output logic                 en_stream,
   output logic                 op_1,
   output logic                 sel_mult,
   output logic                 Ld_p1_xi,
   output logic                 Ld_data,
   output logic                 en_sum,
   output logic [SEL_XI2_W-1:0] sel_xi2
`ifdef INTPOL2_D4_CTRL_CNT_EN
   ,
   output logic [15:0]          out_cnt
`endif
);

   localparam logic [CNT_W-1:0] I_LAST = CNT_W'(N_POINTS - 1);

   state_t           state;
   logic [CNT_W-1:0] i;

   // State register, point counter and state-derived strobes.  Each strobe is
   // loaded with its value for the state being entered, so it is a clean
   // register output aligned with the state it belongs to.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         i         <= '0;
         busy      <= 1'b0;
         clear     <= 1'b0;
         op_1      <= 1'b0;
         sel_mult  <= 1'b0;
         Ld_p1_xi  <= 1'b0;
         Ld_data   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         busy      <= 1'b1;
         clear     <= 1'b0;
         op_1      <= 1'b0;
         sel_mult  <= 1'b0;
         Ld_p1_xi  <= 1'b0;
         Ld_data   <= 1'b0;
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD0;
                  clear <= 1'b1;
               end else begin
                  busy  <= 1'b0;
               end
            end
            LOAD0: if (in_valid) state <= LOAD1;
            LOAD1: if (in_valid) state <= LOAD2;
            LOAD2: begin
               if (in_valid) begin
                  state <= COEF;
                  op_1  <= 1'b1;
                  clear <= 1'b1;
               end
            end
            COEF: begin
               i        <= '0;
               state    <= MUL1;
               Ld_p1_xi <= 1'b1;
            end
            MUL1: begin
               state    <= MUL2;
               sel_mult <= 1'b1;
               Ld_data  <= 1'b1;
            end
            MUL2: begin
               state     <= OUT;
               out_valid <= 1'b1;
               sel_mult  <= 1'b1;
            end
            OUT: begin
               if (out_ready) begin
                  if (i == I_LAST) begin
                     state <= SHIFT;
                  end else begin
                     i        <= i + CNT_W'(1);
                     state    <= MUL1;
                     Ld_p1_xi <= 1'b1;
                  end
               end else begin
                  out_valid <= 1'b1;
                  sel_mult  <= 1'b1;
               end
            end
            SHIFT: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (in_valid) begin
                  state <= COEF;
                  op_1  <= 1'b1;
                  clear <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Handshake-qualified strobes: they must coincide with the accepting edge,
   // so they are decoded from the state register and the live handshake.
   always_comb begin
      in_ready  = 1'b0;
      Ld_M0     = 1'b0;
      Ld_M1     = 1'b0;
      Ld_M2     = 1'b0;
      en_stream = 1'b0;
      en_sum    = 1'b0;
      sel_xi2   = SEL_XI2_HOLD;
      case (state)
         LOAD0: begin
            in_ready = 1'b1;
            Ld_M0    = in_valid;
         end
         LOAD1: begin
            in_ready = 1'b1;
            Ld_M1    = in_valid;
         end
         LOAD2: begin
            in_ready = 1'b1;
            Ld_M2    = in_valid;
         end
         OUT: begin
            if (out_ready && (i != I_LAST)) begin
               en_sum  = 1'b1;
               sel_xi2 = (i == '0) ? SEL_XI2_FIRST : SEL_XI2_STEP;
            end
         end
         SHIFT: begin
            if (!stop) begin
               in_ready  = 1'b1;
               en_stream = in_valid;
            end
         end
         default: begin
         end
      endcase
   end

`ifdef INTPOL2_D4_CTRL_CNT_EN
   // Accepted-result counter, restarted at the beginning of every run.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_cnt <= '0;
      end else if ((state == IDLE) && start) begin
         out_cnt <= '0;
      end else if (out_valid && out_ready) begin
         out_cnt <= out_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_intpol2_d4_ctrl.sv
// Randomized bench for intpol2_d4_ctrl.  A procedural reference thread walks
// through a run as nested loops (three loads, then windows of N_POINTS
// multiply/output steps, then a slide) and publishes the expected strobes for
// every cycle; a negedge monitor compares them with the controller outputs.
// Directed asynchronous-reset and reload checks follow the random phase.
module tb_intpol2_d4_ctrl;
   import intpol2_d4_pkg::*;

   localparam int unsigned N_POINTS = 4;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned RND_CYC  = 4000;

   logic clk = 1'b0;
   logic rstn;
   logic start, stop, in_valid, out_ready;
   logic busy, in_ready, out_valid, clear, Ld_M0, Ld_M1, Ld_M2;
   logic en_stream, op_1, sel_mult, Ld_p1_xi, Ld_data, en_sum;
   logic [1:0] sel_xi2;
`ifdef INTPOL2_D4_CTRL_CNT_EN
   logic [15:0] out_cnt;
`endif

   intpol2_d4_ctrl #(.N_POINTS(N_POINTS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .start(start), .stop(stop), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .clear(clear), .Ld_M0(Ld_M0), .Ld_M1(Ld_M1), .Ld_M2(Ld_M2),
      .en_stream(en_stream), .op_1(op_1), .sel_mult(sel_mult),
      .Ld_p1_xi(Ld_p1_xi), .Ld_data(Ld_data), .en_sum(en_sum),
      .sel_xi2(sel_xi2)
`ifdef INTPOL2_D4_CTRL_CNT_EN
      , .out_cnt(out_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   // Expected strobes for the current cycle
   logic e_busy, e_in_ready, e_out_valid, e_clear, e_op_1, e_sel_mult;
   logic e_ld_p1_xi, e_ld_data, e_en_sum, e_en_stream;
   logic [2:0] e_ldm;
   logic [1:0] e_sel_xi2;
   int unsigned e_cnt = 0;

   wire [14:0] obs = {busy, in_ready, out_valid, clear, Ld_M0, Ld_M1, Ld_M2,
                      en_stream, op_1, sel_mult, Ld_p1_xi, Ld_data, en_sum, sel_xi2};
   wire [14:0] exp_v = {e_busy, e_in_ready, e_out_valid, e_clear, e_ldm[0], e_ldm[1], e_ldm[2],
                        e_en_stream, e_op_1, e_sel_mult, e_ld_p1_xi, e_ld_data, e_en_sum, e_sel_xi2};

   task automatic clr_exp();
      e_busy = 1'b0; e_in_ready = 1'b0; e_out_valid = 1'b0; e_clear = 1'b0;
      e_op_1 = 1'b0; e_sel_mult = 1'b0; e_ld_p1_xi = 1'b0; e_ld_data = 1'b0;
      e_en_sum = 1'b0; e_en_stream = 1'b0; e_ldm = 3'b000; e_sel_xi2 = SEL_XI2_HOLD;
   endtask

   // Advance to the next cycle, after the driver has applied its inputs
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference thread: one iteration of the outer loop is one run
   initial begin : ref_model
      bit acc, leave, first;
      clr_exp();
      @(posedge rstn);
      #1;
      forever begin
         clr_exp();
         while (!start) begin
            step();
            clr_exp();
         end
         step();
         e_cnt = 0;
         first = 1'b1;
         for (int k = 0; k < 3; k++) begin
            do begin
               clr_exp();
               e_busy = 1'b1; e_in_ready = 1'b1; e_clear = first; first = 1'b0;
               e_ldm[k] = in_valid;
               acc = in_valid;
               step();
            end while (!acc);
         end
         forever begin
            clr_exp(); e_busy = 1'b1; e_op_1 = 1'b1; e_clear = 1'b1;
            step();
            for (int p = 0; p < int'(N_POINTS); p++) begin
               clr_exp(); e_busy = 1'b1; e_ld_p1_xi = 1'b1;
               step();
               clr_exp(); e_busy = 1'b1; e_sel_mult = 1'b1; e_ld_data = 1'b1;
               step();
               do begin
                  clr_exp(); e_busy = 1'b1; e_out_valid = 1'b1; e_sel_mult = 1'b1;
                  acc = out_ready;
                  if (acc && (p < int'(N_POINTS) - 1)) begin
                     e_en_sum  = 1'b1;
                     e_sel_xi2 = (p == 0) ? SEL_XI2_FIRST : SEL_XI2_STEP;
                  end
                  step();
                  if (acc) e_cnt = (e_cnt + 1) % 65536;
               end while (!acc);
            end
            leave = 1'b0;
            acc   = 1'b0;
            do begin
               clr_exp(); e_busy = 1'b1;
               if (stop) begin
                  leave = 1'b1;
               end else begin
                  e_in_ready = 1'b1; e_en_stream = in_valid; acc = in_valid;
               end
               step();
            end while (!leave && !acc);
            if (leave) break;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("strobes", 32'(obs), 32'(exp_v));
`ifdef INTPOL2_D4_CTRL_CNT_EN
         check("out_cnt", 32'(out_cnt), e_cnt);
`endif
      end
   end

   initial begin : stim
      int unsigned p_iv, p_or, p_stop;
      int found, ldm_cnt;
      rstn = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      p_iv = 2; p_or = 3; p_stop = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outs", 32'(obs), 32'd0);
`ifdef INTPOL2_D4_CTRL_CNT_EN
      check("reset_cnt", 32'(out_cnt), 32'd0);
`endif
      @(posedge clk);
      #1;
      rstn = 1'b1;
      chk_on = 1'b1;
      for (int c = 0; c < int'(RND_CYC); c++) begin
         // re-bias every 150 cycles so long stalls and stop/restart both occur
         if (c % 150 == 0) begin
            p_iv   = $urandom_range(1, 4);
            p_or   = $urandom_range(1, 4);
            p_stop = $urandom_range(0, 2);
         end
         start     = ($urandom % 8) != 0;
         stop      = ($urandom % 8) < p_stop;
         in_valid  = ($urandom % 4) < p_iv;
         out_ready = ($urandom % 4) < p_or;
         @(posedge clk);
         #1;
      end

      // Asynchronous reset while the controller sits in MUL2
      chk_on = 1'b0;
      start = 1'b1; stop = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      found = 0;
      for (int c = 0; c < 200 && found == 0; c++) begin
         @(negedge clk);
         if (Ld_data) found = 1;
      end
      check("reach_mul2", 32'(found), 32'd1);
      rstn = 1'b0;
      #1;
      check("async_rst_outs", 32'(obs), 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      rstn  = 1'b1;
      @(negedge clk);
      check("idle_after_rst", 32'(obs), 32'd0);
      @(posedge clk);
      #1;
      start = 1'b1;
      ldm_cnt = 0;
      repeat (5) begin
         @(negedge clk);
         ldm_cnt += int'(Ld_M0) + int'(Ld_M1) + int'(Ld_M2);
      end
      check("reload_ldm", 32'(ldm_cnt), 32'd3);
      check("coef_after_reload", 32'(op_1), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
